align_shift: RTL
================

ALIGN_SHIFT -- requirements
Module: align_shift

Interface
REQ-001 Parameter MW, default 28, mantissa width including guard/round/sticky positions.
REQ-002 Parameter EW, default 8, exponent width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset; one clock, reset is synchronous and active-high.
REQ-005 in_valid  input  1  upstream comparison result valid.
REQ-006 in_ready  output  1  stage accepts input this cycle.
REQ-007 Comp  input  1  1 = A operand is larger, 0 = B larger.
REQ-008 SA, SB  input  1 each  operand signs.
REQ-009 Emax  input  EW  larger exponent.
REQ-010 Mmax  input  MW  larger-operand mantissa.
REQ-011 Mshift  input  MW  smaller-operand mantissa, to be aligned.
REQ-012 Dexp  input  5  exponent difference, pre-saturated upstream to at most 28.
REQ-013 out_valid  output  1  aligned result valid.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 Sres, Eres, Mbig, Malign, Esub  outputs  1/EW/MW/MW/1: result sign (SA if Comp else SB), Emax, Mmax, aligned small mantissa, effective subtract (SA^SB).

Function
REQ-016 Malign SHALL equal Mshift logically shifted right by Dexp, with bit 0 ORed with the OR of all bits shifted out (sticky).
REQ-017 Dexp values 28..31 SHALL produce Malign = {all zeros, OR of all Mshift bits} in bit 0.
REQ-018 Dexp = 0 SHALL pass Mshift unchanged.
REQ-019 Shift SHALL be split over two pipeline stages: stage 1 shifts by 8*Dexp[4:3] (0/8/16/24) with partial sticky, stage 2 by Dexp[2:0] and merges sticky; Dexp>=28 forced to full-flush in stage 1.
REQ-020 Latency SHALL be exactly 2 cycles from accepted input (in_valid & in_ready) to out_valid, with no backpressure.
REQ-021 Throughput SHALL be one transaction per cycle when out_ready is held high.
REQ-022 Each stage holds a valid bit; a stage SHALL load when it is empty or its contents advance the same cycle.
REQ-023 in_ready SHALL equal ~s1_valid | (~s2_valid | out_ready) (combinational, no in_valid dependence).
REQ-024 Output registers and out_valid SHALL hold stable while out_valid & ~out_ready.
REQ-025 Simultaneous accept at input and release at output SHALL not lose or duplicate a transaction.
REQ-026 Sres, Eres, Mbig, Esub SHALL travel in lock-step with Malign through both stages.
REQ-027 Data registers SHALL load only on stage advance (no toggling on bubbles).

Reset
REQ-028 rst SHALL clear both stage valid bits; out_valid = 0 the cycle after rst is sampled high.
REQ-029 rst SHALL zero Sres, Eres, Mbig, Malign, Esub.
REQ-030 in_ready SHALL be 1 in the first cycle after reset.
REQ-031 rst asserted mid-operation SHALL discard all in-flight transactions; no output for them after reset.

Structure
REQ-032 MW, EW, max-shift constant (28) and the 37-bit operand field offsets SHALL live in the shared FP adder package.
REQ-033 One sub-module, sticky_shr (combinational right shift with sticky, parameterised width and shift), SHALL be instantiated once per stage.
REQ-034 No latches; all outputs registered.

Verification
REQ-035 Mshift=28'h0000_0F0, Dexp=4, out_ready=1 -> after 2 cycles Malign=28'h000_000F, sticky 0.
REQ-036 Mshift=28'h000_0001, Dexp=1 -> Malign=28'h000_0001 (sticky set); Mshift=28'h800_0000, Dexp=28 -> Malign=28'h000_0001.
REQ-037 Mshift=28'h0, Dexp=28 -> Malign=0; Dexp=0, Mshift=28'hABC_DEF0 -> Malign unchanged.
REQ-038 Stream 10 back-to-back inputs, out_ready low 3 cycles mid-stream -> in_ready drops after both stages full, all 10 outputs in order, none lost or duplicated.
REQ-039 SA=1, SB=0, Comp=0 -> Sres=0, Esub=1; Comp=1 -> Sres=1.
REQ-040 rst pulsed with two transactions in flight -> out_valid=0 next cycle, outputs zero, in_ready=1, neither transaction ever appears.

Source files
------------

// File: rtl/align_shift_pkg.sv
// Shared FP adder constants: datapath widths, the alignment shift limit
// and the bit layout of a packed 37-bit operand (sign | exponent | mantissa).
package align_shift_pkg;

    localparam int FP_MW     = 28;
    localparam int FP_EW     = 8;
    localparam int MAX_SHIFT = 28;
    localparam int DEXP_W    = 5;

    // Packed operand field offsets: {sign, exponent[7:0], mantissa[27:0]}
    localparam int OP_W        = 1 + FP_EW + FP_MW;
    localparam int OP_SIGN_BIT = OP_W - 1;
    localparam int OP_EXP_MSB  = OP_W - 2;
    localparam int OP_EXP_LSB  = FP_MW;
    localparam int OP_MANT_MSB = FP_MW - 1;
    localparam int OP_MANT_LSB = 0;

    // Any difference at or beyond the mantissa width pushes every bit into sticky
    function automatic logic is_full_flush(input logic [DEXP_W-1:0] dexp);
        return dexp >= DEXP_W'(MAX_SHIFT);
    endfunction

endpackage

// File: rtl/sticky_shr.sv
// Combinational logical right shift that folds every shifted-out bit
// into bit 0 of the result, so later rounding still sees a nonzero tail.
module sticky_shr
    import align_shift_pkg::*;
#(
    parameter int W  = 28,
    parameter int SW = 5
) (
    input  logic [W-1:0]  din,
    input  logic [SW-1:0] sh,
    output logic [W-1:0]  dout
);

    logic [W-1:0] shifted;
    logic [W-1:0] lost_mask;
    logic         sticky;

    // Shift, then OR together the bits that fell off the bottom
    always_comb begin
        shifted   = din >> sh;
        lost_mask = ~({W{1'b1}} << sh);
        sticky    = |(din & lost_mask);
        dout      = shifted;
        dout[0]   = shifted[0] | sticky;
    end

endmodule

// File: rtl/align_shift.sv
// Two-stage mantissa alignment for the FP adder. Stage 1 does the coarse
// shift in multiples of 8 (or a full flush for huge differences), stage 2
// the fine 0..7 shift. Sticky bits are folded into bit 0 at each stage,
// which is equivalent to collecting them all at once because bit 0 itself
// is part of whatever stage 2 shifts out. Both stages use a valid bit with
// ready/valid handshaking so the pipe runs at full rate and stalls cleanly.
module align_shift
    import align_shift_pkg::*;
#(
    parameter int MW = FP_MW,
    parameter int EW = FP_EW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          Comp,
    input  logic          SA,
    input  logic          SB,
    input  logic [EW-1:0] Emax,
    input  logic [MW-1:0] Mmax,
    input  logic [MW-1:0] Mshift,
    input  logic [4:0]    Dexp,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          Sres,
    output logic [EW-1:0] Eres,
    output logic [MW-1:0] Mbig,
    output logic [MW-1:0] Malign,
    output logic          Esub
);

    // Stage 1 registers
    logic          s1_valid;
    logic          s1_sres;
    logic [EW-1:0] s1_eres;
    logic [MW-1:0] s1_mbig;
    logic [MW-1:0] s1_malign;
    logic          s1_esub;
    logic [2:0]    s1_fine;

    // Handshake and datapath intermediates
    logic          s1_load;
    logic          s2_load;
    logic          flush;
    logic [4:0]    coarse_sh;
    logic [MW-1:0] coarse_out;
    logic [MW-1:0] s1_malign_next;
    logic [2:0]    s1_fine_next;
    logic [MW-1:0] fine_out;

    // Output stage is out_valid itself; accept whenever something downstream frees a slot
    assign in_ready = ~s1_valid | (~out_valid | out_ready);
    assign s1_load  = in_valid & in_ready;
    assign s2_load  = s1_valid & (~out_valid | out_ready);

    assign coarse_sh = {Dexp[4:3], 3'b000};
    assign flush     = is_full_flush(Dexp);

    sticky_shr #(
        .W  (MW),
        .SW (5)
    ) u_coarse (
        .din  (Mshift),
        .sh   (coarse_sh),
        .dout (coarse_out)
    );

    // Full flush leaves only the OR of the whole mantissa; fine shift is then irrelevant
    always_comb begin
        s1_malign_next = coarse_out;
        s1_fine_next   = Dexp[2:0];
        if (flush) begin
            s1_malign_next = {{(MW-1){1'b0}}, |Mshift};
            s1_fine_next   = 3'b000;
        end
    end

    sticky_shr #(
        .W  (MW),
        .SW (3)
    ) u_fine (
        .din  (s1_malign),
        .sh   (s1_fine),
        .dout (fine_out)
    );

    // Valid bits: a stage fills on load, empties when its contents move on without a refill
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if (s2_load) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Stage 1 data captures only on an accepted input so bubbles do not toggle it
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sres   <= 1'b0;
            s1_eres   <= '0;
            s1_mbig   <= '0;
            s1_malign <= '0;
            s1_esub   <= 1'b0;
            s1_fine   <= 3'b000;
        end else if (s1_load) begin
            s1_sres   <= Comp ? SA : SB;
            s1_eres   <= Emax;
            s1_mbig   <= Mmax;
            s1_malign <= s1_malign_next;
            s1_esub   <= SA ^ SB;
            s1_fine   <= s1_fine_next;
        end
    end

    // Output registers advance with stage 1 and otherwise hold through stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            Sres   <= 1'b0;
            Eres   <= '0;
            Mbig   <= '0;
            Malign <= '0;
            Esub   <= 1'b0;
        end else if (s2_load) begin
            Sres   <= s1_sres;
            Eres   <= s1_eres;
            Mbig   <= s1_mbig;
            Malign <= fine_out;
            Esub   <= s1_esub;
        end
    end

endmodule
